// File: rtl/ad9122_spi_xfer_engine.sv
// AD9122 SPI transaction engine: serialises one write, read or delay command
// at a time onto the 3-wire SPI port (SCLK, SDIO split into out/in/dir, CS_N).
// Optional build macro SPI_4WIRE_EN: read data is taken from the separate SDO
// line and SDIO stays an output for the whole read.
module ad9122_spi_xfer_engine #(
  parameter int CLK_DIV  = 4,
  parameter int INFO_LEN = 8,
  parameter int DATA_LEN = 8,
  parameter int CS_GAP   = 4
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [1:0]                   i_mode_sel,
  input  logic [INFO_LEN+DATA_LEN-1:0] i_wr_infodata,
  input  logic [INFO_LEN-1:0]          i_rd_info,
  input  logic [15:0]                  i_delay_cnt,
  output logic [DATA_LEN-1:0]          o_rd_data,
  output logic                         o_sclk,
  output logic                         o_sda,
  output logic                         o_sda_dir,
  input  logic                         i_sda,
  input  logic                         i_sdo,
  output logic                         o_cs_n,
  output logic                         o_busy
);

  localparam int FRAME = INFO_LEN + DATA_LEN;
  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME);
  localparam int GAP_W = $clog2(CS_GAP);
  localparam int DLY_W = 16 + $clog2(2 * CLK_DIV) + 1;

  localparam logic [1:0] MODE_WR  = 2'b00;
  localparam logic [1:0] MODE_RD  = 2'b01;
  localparam logic [1:0] MODE_DLY = 2'b10;

  typedef enum logic [2:0] {
    IDLE, SHIFT_OUT, TURN, SHIFT_IN, CS_HOLD, DELAY, DONE, GAP
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          mode_q;
  logic [FRAME-1:0]    tx_sr;
  logic [DATA_LEN-1:0] rx_sr;
  logic [DATA_LEN-1:0] rd_data;
  logic [PH_W-1:0]     phase_cnt;
  logic                half;
  logic [BIT_W-1:0]    bit_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [DLY_W-1:0]    dly_cnt;
  logic [DLY_W-1:0]    dly_total;
  logic                phase_end;
  logic                is_rd;
  logic                sdi;

`ifdef SPI_4WIRE_EN
  logic unused_sda;
  assign sdi        = i_sdo;
  assign unused_sda = i_sda;
`else
  logic unused_sdo;
  assign sdi        = i_sda;
  assign unused_sdo = i_sdo;
`endif

  assign phase_end = (phase_cnt == PH_W'(CLK_DIV - 1));
  assign is_rd     = (mode_q == MODE_RD);
  assign dly_total = DLY_W'(i_delay_cnt) * DLY_W'(2 * CLK_DIV);

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: each SPI bit is a low half then a high half of CLK_DIV cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          case (i_mode_sel)
            MODE_WR, MODE_RD: state_nxt = SHIFT_OUT;
            MODE_DLY:         state_nxt = (i_delay_cnt == 16'd0) ? DONE : DELAY;
            default:          state_nxt = DONE;
          endcase
        end
      end
      SHIFT_OUT: begin
        if (phase_end && half) begin
          if (is_rd && bit_cnt == BIT_W'(INFO_LEN - 1)) state_nxt = TURN;
          else if (bit_cnt == BIT_W'(FRAME - 1))        state_nxt = CS_HOLD;
        end
      end
      TURN:     if (phase_end) state_nxt = SHIFT_IN;
      SHIFT_IN: if (phase_end && half && bit_cnt == BIT_W'(FRAME - 1)) state_nxt = CS_HOLD;
      CS_HOLD:  if (phase_end) state_nxt = DONE;
      DELAY:    if (dly_cnt == DLY_W'(1)) state_nxt = DONE;
      DONE:     state_nxt = GAP;
      GAP:      if (gap_cnt == GAP_W'(CS_GAP - 1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Shadow registers, phase/bit counters and shift registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      mode_q    <= MODE_WR;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rd_data   <= '0;
      phase_cnt <= '0;
      half      <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      dly_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          phase_cnt <= '0;
          half      <= 1'b0;
          bit_cnt   <= '0;
          gap_cnt   <= '0;
          if (i_valid) begin
            mode_q  <= i_mode_sel;
            tx_sr   <= (i_mode_sel == MODE_RD) ? {i_rd_info, {DATA_LEN{1'b0}}} : i_wr_infodata;
            dly_cnt <= dly_total - DLY_W'(1);
          end
        end
        SHIFT_OUT, TURN, SHIFT_IN: begin
          if (phase_end) begin
            phase_cnt <= '0;
            half      <= ~half;
            if (!half) begin
              // Low-to-high transition is the rising SCLK edge: sample read data here
              if (state != SHIFT_OUT) rx_sr <= {rx_sr[DATA_LEN-2:0], sdi};
            end else begin
              tx_sr <= {tx_sr[FRAME-2:0], 1'b0};
              if (bit_cnt != BIT_W'(FRAME - 1)) bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        CS_HOLD: begin
          if (phase_end) begin
            phase_cnt <= '0;
            // Publish the read byte in the same cycle CS_N rises
            if (is_rd) rd_data <= rx_sr;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        DELAY:   dly_cnt <= dly_cnt - DLY_W'(1);
        DONE:    gap_cnt <= '0;
        GAP:     gap_cnt <= gap_cnt + GAP_W'(1);
        default: phase_cnt <= '0;
      endcase
    end
  end

  // Output decode from state and datapath registers
  always_comb begin
    o_cs_n    = !(state inside {SHIFT_OUT, TURN, SHIFT_IN, CS_HOLD});
    o_sclk    = half && (state inside {SHIFT_OUT, TURN, SHIFT_IN});
    o_sda     = (state == SHIFT_OUT) && tx_sr[FRAME-1];
`ifdef SPI_4WIRE_EN
    o_sda_dir = 1'b1;
`else
    o_sda_dir = !(is_rd && (state inside {TURN, SHIFT_IN, CS_HOLD}));
`endif
    o_ready   = (state == DONE);
    o_busy    = (state != IDLE);
    o_rd_data = rd_data;
  end

endmodule

// File: tb/tb_ad9122_spi_xfer_engine.sv
// Directed self-checking bench for ad9122_spi_xfer_engine at default parameters.
module tb_ad9122_spi_xfer_engine;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_mode_sel;
  logic [15:0] i_wr_infodata;
  logic [7:0]  i_rd_info;
  logic [15:0] i_delay_cnt;
  logic [7:0]  o_rd_data;
  logic        o_sclk, o_sda, o_sda_dir, i_sda, i_sdo, o_cs_n, o_busy;

  int checks = 0;
  int errors = 0;

  // Results of the last run_cmd
  int          r_cs_low, r_rises, r_ready_cnt, r_ready_c, r_cs_rise_c;
  int          r_dir0_first, r_dir0_cnt, r_sda_bad;
  logic [15:0] r_bits;
  logic [7:0]  r_rd_at_ready;
  logic        r_timeout;

  ad9122_spi_xfer_engine dut (
    .clk_in(clk_in), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode_sel(i_mode_sel), .i_wr_infodata(i_wr_infodata), .i_rd_info(i_rd_info),
    .i_delay_cnt(i_delay_cnt), .o_rd_data(o_rd_data), .o_sclk(o_sclk), .o_sda(o_sda),
    .o_sda_dir(o_sda_dir), .i_sda(i_sda), .i_sdo(i_sdo), .o_cs_n(o_cs_n), .o_busy(o_busy)
  );

  always #5 clk_in = ~clk_in;

  // Issue one command and observe it at every falling clk_in edge until the engine is idle.
  // Cycle numbers are relative to the accept cycle (cycle 0).
  task automatic run_cmd(input logic [1:0] mode, input logic [15:0] wr, input logic [7:0] rdi,
                         input logic [15:0] dly, input logic [7:0] sda_rep, input logic [7:0] sdo_rep);
    int c, falls, idx;
    logic prev_sclk, prev_cs;
    @(negedge clk_in);
    i_valid = 1'b1; i_mode_sel = mode; i_wr_infodata = wr; i_rd_info = rdi; i_delay_cnt = dly;
    @(negedge clk_in);
    i_valid = 1'b0;
    i_mode_sel = ~mode; i_wr_infodata = ~wr; i_rd_info = ~rdi; i_delay_cnt = 16'hFFFF;
    r_cs_low = 0; r_rises = 0; r_ready_cnt = 0; r_ready_c = -1; r_cs_rise_c = -1;
    r_dir0_first = -1; r_dir0_cnt = 0; r_sda_bad = 0; r_bits = '0; r_rd_at_ready = '0;
    r_timeout = 1'b0; prev_sclk = 1'b0; prev_cs = 1'b1; falls = 0; c = 1;
    forever begin
      if (!o_cs_n) r_cs_low++;
      if (o_sclk && !prev_sclk) begin r_rises++; r_bits = {r_bits[14:0], o_sda}; end
      if (!o_sclk && prev_sclk) begin
        falls++;
        if (falls >= 8 && falls <= 15) begin
          idx = 15 - falls;
          i_sda = sda_rep[idx];
          i_sdo = sdo_rep[idx];
        end
      end
      if (o_cs_n && !prev_cs && r_cs_rise_c < 0) r_cs_rise_c = c;
      if (!o_sda_dir) begin
        r_dir0_cnt++;
        if (r_dir0_first < 0) r_dir0_first = c;
        if (o_sda) r_sda_bad++;
      end
      if (o_ready) begin r_ready_cnt++; r_ready_c = c; r_rd_at_ready = o_rd_data; end
      prev_sclk = o_sclk; prev_cs = o_cs_n;
      if (!o_busy) break;
      if (c >= 2000) begin r_timeout = 1'b1; break; end
      @(negedge clk_in);
      c++;
    end
    i_sda = 1'b0; i_sdo = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_mode_sel = 2'b00; i_wr_infodata = '0; i_rd_info = '0;
    i_delay_cnt = '0; i_sda = 1'b0; i_sdo = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({o_cs_n, o_sclk, o_sda, o_sda_dir, o_ready, o_busy} !== 6'b100100) begin
      errors++;
      $display("FAIL reset_outputs: cs_n/sclk/sda/dir/ready/busy=%b required 100100",
               {o_cs_n, o_sclk, o_sda, o_sda_dir, o_ready, o_busy});
    end
    checks++;
    if (o_rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_rd_data: got %h required 00", o_rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    run_cmd(2'b00, 16'h0020, 8'h00, 16'd0, 8'h00, 8'h00);
    checks++;
    if (r_timeout !== 1'b0) begin errors++; $display("FAIL write_timeout: got %b required 0", r_timeout); end
    checks++;
    if (r_cs_low != 132) begin errors++; $display("FAIL write_cs_low: got %0d required 132", r_cs_low); end
    checks++;
    if (r_rises != 16) begin errors++; $display("FAIL write_sclk_rises: got %0d required 16", r_rises); end
    checks++;
    if (r_bits !== 16'h0020) begin errors++; $display("FAIL write_bits: got %h required 0020", r_bits); end
    checks++;
    if (r_ready_cnt != 1 || r_ready_c != 133) begin
      errors++; $display("FAIL write_ready: count %0d at cycle %0d required 1 at 133", r_ready_cnt, r_ready_c);
    end
    checks++;
    if (r_cs_rise_c != 133) begin errors++; $display("FAIL write_cs_rise: got %0d required 133", r_cs_rise_c); end
    checks++;
    if (r_dir0_cnt != 0) begin errors++; $display("FAIL write_dir: dir low %0d cycles required 0", r_dir0_cnt); end
  endtask

  task automatic test_read();
    logic [7:0] exp_rd;
`ifdef SPI_4WIRE_EN
    exp_rd = 8'h1F;
    run_cmd(2'b01, 16'h0000, 8'h99, 16'd0, 8'h00, 8'h1F);
    checks++;
    if (r_bits !== 16'h9900) begin errors++; $display("FAIL read_bits: got %h required 9900", r_bits); end
    checks++;
    if (r_dir0_cnt != 0) begin errors++; $display("FAIL read_dir_4w: dir low %0d cycles required 0", r_dir0_cnt); end
`else
    exp_rd = 8'h07;
    run_cmd(2'b01, 16'h0000, 8'h98, 16'd0, 8'h07, 8'hE5);
    checks++;
    if (r_bits !== 16'h9800) begin errors++; $display("FAIL read_bits: got %h required 9800", r_bits); end
    checks++;
    if (r_dir0_first != 65) begin errors++; $display("FAIL read_dir_fall: got %0d required 65", r_dir0_first); end
    checks++;
    if (r_dir0_cnt != 68) begin errors++; $display("FAIL read_dir_len: got %0d required 68", r_dir0_cnt); end
`endif
    checks++;
    if (r_timeout !== 1'b0) begin errors++; $display("FAIL read_timeout: got %b required 0", r_timeout); end
    checks++;
    if (r_sda_bad != 0) begin errors++; $display("FAIL read_sda_turn: sda high %0d cycles required 0", r_sda_bad); end
    checks++;
    if (r_cs_low != 132) begin errors++; $display("FAIL read_cs_low: got %0d required 132", r_cs_low); end
    checks++;
    if (r_ready_cnt != 1 || r_ready_c != 133) begin
      errors++; $display("FAIL read_ready: count %0d at cycle %0d required 1 at 133", r_ready_cnt, r_ready_c);
    end
    checks++;
    if (r_rd_at_ready !== exp_rd) begin
      errors++; $display("FAIL read_data: got %h required %h", r_rd_at_ready, exp_rd);
    end
    // A following write must not disturb the captured byte
    run_cmd(2'b00, 16'h5AA5, 8'h00, 16'd0, 8'h00, 8'h00);
    checks++;
    if (r_bits !== 16'h5AA5) begin errors++; $display("FAIL write2_bits: got %h required 5aa5", r_bits); end
    checks++;
    if (r_rd_at_ready !== exp_rd || o_rd_data !== exp_rd) begin
      errors++; $display("FAIL read_data_hold: got %h/%h required %h", r_rd_at_ready, o_rd_data, exp_rd);
    end
  endtask

  task automatic test_delay();
    logic [7:0] held;
    held = o_rd_data;
    run_cmd(2'b10, 16'hFFFF, 8'hFF, 16'd4, 8'h00, 8'h00);
    checks++;
    if (r_ready_cnt != 1 || r_ready_c != 32) begin
      errors++; $display("FAIL delay4_ready: count %0d at cycle %0d required 1 at 32", r_ready_cnt, r_ready_c);
    end
    checks++;
    if (r_cs_low != 0 || r_rises != 0) begin
      errors++; $display("FAIL delay4_quiet: cs_low %0d rises %0d required 0 0", r_cs_low, r_rises);
    end
    run_cmd(2'b10, 16'h0000, 8'h00, 16'd0, 8'h00, 8'h00);
    checks++;
    if (r_ready_cnt != 1 || r_ready_c != 1) begin
      errors++; $display("FAIL delay0_ready: count %0d at cycle %0d required 1 at 1", r_ready_cnt, r_ready_c);
    end
    run_cmd(2'b11, 16'hABCD, 8'hCD, 16'd9, 8'h00, 8'h00);
    checks++;
    if (r_ready_c != 1 || r_cs_low != 0 || r_rises != 0) begin
      errors++; $display("FAIL reserved: ready at %0d cs_low %0d rises %0d required 1 0 0",
                         r_ready_c, r_cs_low, r_rises);
    end
    checks++;
    if (o_rd_data !== held) begin errors++; $display("FAIL delay_rd_hold: got %h required %h", o_rd_data, held); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cmds [3];
    logic [15:0] frames [3];
    int gaps [2];
    int c, nf, nfall, readies, last_rise;
    logic pending, prev_sclk, prev_cs;
    logic [15:0] bits;
    cmds[0] = 16'h0000; cmds[1] = 16'h0300; cmds[2] = 16'h0400;
    frames[0] = '1; frames[1] = '1; frames[2] = '1; gaps[0] = -1; gaps[1] = -1;
    nf = 0; nfall = 0; readies = 0; last_rise = -1; pending = 1'b0;
    prev_sclk = 1'b0; prev_cs = 1'b1; bits = '0;
    @(negedge clk_in);
    i_valid = 1'b1; i_mode_sel = 2'b00; i_wr_infodata = cmds[0];
    for (c = 0; c < 1000; c++) begin
      @(negedge clk_in);
      if (pending) begin
        pending = 1'b0;
        if (readies < 3) i_wr_infodata = cmds[readies];
        else i_valid = 1'b0;
      end
      if (!o_cs_n && prev_cs) begin
        if (last_rise >= 0 && nfall < 2) gaps[nfall] = c - last_rise;
        if (last_rise >= 0) nfall++;
      end
      if (!o_cs_n && o_sclk && !prev_sclk) bits = {bits[14:0], o_sda};
      if (o_cs_n && !prev_cs) begin
        if (nf < 3) frames[nf] = bits;
        nf++; bits = '0; last_rise = c;
      end
      if (o_ready) begin readies++; pending = 1'b1; end
      prev_sclk = o_sclk; prev_cs = o_cs_n;
      if (readies == 3 && !pending && !o_busy) break;
    end
    i_valid = 1'b0;
    checks++;
    if (readies != 3 || nf != 3) begin
      errors++; $display("FAIL b2b_count: readies %0d frames %0d required 3 3", readies, nf);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (frames[i] !== cmds[i]) begin
        errors++; $display("FAIL b2b_frame%0d: got %h required %h", i, frames[i], cmds[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (gaps[i] != 6) begin errors++; $display("FAIL b2b_gap%0d: got %0d required 6", i, gaps[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    int rises, seen_ready;
    logic prev_sclk, hit;
    @(negedge clk_in);
    i_valid = 1'b1; i_mode_sel = 2'b01; i_rd_info = 8'h98;
    @(negedge clk_in);
    i_valid = 1'b0;
    rises = 0; prev_sclk = 1'b0; hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (o_sclk && !prev_sclk) rises++;
      prev_sclk = o_sclk;
      if (rises == 7) begin hit = 1'b1; break; end
      @(negedge clk_in);
    end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_edge7: reached %0d rises required 7", rises); end
    rst = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({o_cs_n, o_sclk, o_sda_dir, o_ready, o_busy} !== 5'b10100) begin
      errors++; $display("FAIL rstmid_outputs: cs_n/sclk/dir/ready/busy=%b required 10100",
                         {o_cs_n, o_sclk, o_sda_dir, o_ready, o_busy});
    end
    checks++;
    if (o_rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_rd_data: got %h required 00", o_rd_data); end
    rst = 1'b0;
    seen_ready = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (o_ready) seen_ready++;
    end
    checks++;
    if (seen_ready != 0) begin errors++; $display("FAIL rstmid_no_ready: got %0d pulses required 0", seen_ready); end
    run_cmd(2'b00, 16'h1234, 8'h00, 16'd0, 8'h00, 8'h00);
    checks++;
    if (r_bits !== 16'h1234 || r_ready_cnt != 1 || r_cs_low != 132) begin
      errors++; $display("FAIL rstmid_recover: bits %h ready %0d cs_low %0d required 1234 1 132",
                         r_bits, r_ready_cnt, r_cs_low);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_delay();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
